// File: rtl/misao_mem_pkg.sv
// Shared types and constants for the misao memory responder.
// Optional feature macro: MISAO_MEM_WPROT_EN (write protection of low addresses).
package misao_mem_pkg;
  localparam int MISAO_ADDR_W = 15;
  localparam int MISAO_DATA_W = 8;

  // Position of each byte in the loader header (little-endian start, then length)
  localparam int HDR_ADDR_LO = 0;
  localparam int HDR_ADDR_HI = 1;
  localparam int HDR_LEN_LO  = 2;
  localparam int HDR_LEN_HI  = 3;
  localparam int HDR_BYTES   = 4;

  typedef enum logic [2:0] {
    ST_ADDR_LO = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_LEN_HI  = 3'd3,
    ST_DATA    = 3'd4,
    ST_RUN     = 3'd5
  } ld_state_t;
endpackage

// File: rtl/misao_mem_responder_if.sv
// Core-side memory bus: strobes, address and write data from the core,
// read data back to it.
interface misao_mem_responder_if;
  import misao_mem_pkg::*;

  logic                    mem_enable_read;
  logic                    mem_enable_write;
  logic                    mem_rw;
  logic [MISAO_ADDR_W-1:0] mem_addr;
  logic [MISAO_DATA_W-1:0] mem_data_out;
  logic [MISAO_DATA_W-1:0] mem_data_in;

  modport master (
    output mem_enable_read, mem_enable_write, mem_rw, mem_addr, mem_data_out,
    input  mem_data_in
  );

  modport slave (
    input  mem_enable_read, mem_enable_write, mem_rw, mem_addr, mem_data_out,
    output mem_data_in
  );
endinterface

// File: rtl/misao_byte_ram.sv
// Byte-wide storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module misao_byte_ram
  import misao_mem_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [MISAO_DATA_W-1:0] wdata,
  input  logic [AW-1:0]           raddr,
  output logic [MISAO_DATA_W-1:0] rdata
);
  logic [MISAO_DATA_W-1:0] mem [DEPTH];

  // Single write port, owner chosen by the responder FSM
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/misao_mem_responder.sv
// Memory responder: a byte loader fills the RAM from a header+payload stream
// while holding the core in reset, then releases the core and serves its
// reads/writes. Out-of-range core accesses raise a sticky oob_err.
// Optional: MISAO_MEM_WPROT_EN drops core writes below WPROT_TOP and raises
// a sticky wprot_err; when undefined wprot_err is tied low.
module misao_mem_responder
  import misao_mem_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int WPROT_TOP = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  misao_mem_responder_if.slave    bus,
  input  logic                    ld_valid,
  input  logic [MISAO_DATA_W-1:0] ld_data,
  output logic                    ld_ready,
  input  logic                    boot_skip,
  output logic                    core_rst,
  output logic                    oob_err,
  output logic                    wprot_err
);
  localparam int AW = $clog2(DEPTH);
  // One extra bit so DEPTH=32768 is representable
  localparam logic [MISAO_ADDR_W:0] DEPTH_LIM = 16'(DEPTH);

  ld_state_t               state, state_nxt;
  logic [15:0]             load_addr, count;
  logic                    in_range, core_acc, run, prot_hit;
  logic                    ram_we;
  logic [AW-1:0]           ram_waddr;
  logic [MISAO_DATA_W-1:0] ram_wdata, ram_rdata;
  logic                    unused_rw;

  assign unused_rw = bus.mem_rw;  // direction is implied by the strobes
  assign in_range  = {1'b0, bus.mem_addr} < DEPTH_LIM;
  assign core_acc  = bus.mem_enable_read | bus.mem_enable_write;
  assign run       = (state == ST_RUN);

`ifdef MISAO_MEM_WPROT_EN
  localparam logic [MISAO_ADDR_W:0] WPROT_LIM = 16'(WPROT_TOP);
  assign prot_hit = bus.mem_enable_write && ({1'b0, bus.mem_addr} < WPROT_LIM);

  // Sticky write-protect violation, only counted while the core runs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                wprot_err <= 1'b0;
    else if (run && prot_hit)  wprot_err <= 1'b1;
`else
  logic [31:0] unused_wprot;
  assign unused_wprot = WPROT_TOP;
  assign prot_hit     = 1'b0;
  assign wprot_err    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_ADDR_LO;
    else        state <= state_nxt;

  // Next state, loader handshake and RAM write-port arbitration
  always_comb begin
    state_nxt = state;
    ld_ready  = (state != ST_RUN);
    ram_we    = 1'b0;
    ram_waddr = load_addr[AW-1:0];
    ram_wdata = ld_data;
    case (state)
      ST_ADDR_LO: if (boot_skip)     state_nxt = ST_RUN;
                  else if (ld_valid) state_nxt = ST_ADDR_HI;
      ST_ADDR_HI: if (ld_valid) state_nxt = ST_LEN_LO;
      ST_LEN_LO:  if (ld_valid) state_nxt = ST_LEN_HI;
      ST_LEN_HI:  if (ld_valid)
                    state_nxt = ({ld_data, count[7:0]} == 16'd0) ? ST_RUN : ST_DATA;
      ST_DATA:    if (ld_valid) begin
                    ram_we = 1'b1;
                    if (count == 16'd1) state_nxt = ST_RUN;
                  end
      ST_RUN: begin
        ram_we    = bus.mem_enable_write && in_range && !prot_hit;
        ram_waddr = bus.mem_addr[AW-1:0];
        ram_wdata = bus.mem_data_out;
      end
      default:    state_nxt = ST_ADDR_LO;
    endcase
  end

  // Header capture and payload address/count tracking; the address wraps
  // naturally because only its low AW bits index the RAM
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      load_addr <= '0;
      count     <= '0;
    end else if (ld_valid) begin
      case (state)
        ST_ADDR_LO: if (!boot_skip) load_addr[7:0] <= ld_data;
        ST_ADDR_HI: load_addr[15:8] <= ld_data;
        ST_LEN_LO:  count[7:0]      <= ld_data;
        ST_LEN_HI:  count[15:8]     <= ld_data;
        ST_DATA: begin
          load_addr <= load_addr + 16'd1;
          count     <= count - 16'd1;
        end
        default: ;
      endcase
    end

  // Core reset lags ST_RUN by one cycle; sticky out-of-range flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      core_rst <= 1'b1;
      oob_err  <= 1'b0;
    end else begin
      core_rst <= !run;
      if (run && core_acc && !in_range) oob_err <= 1'b1;
    end

  misao_byte_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (bus.mem_addr[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign bus.mem_data_in = in_range ? ram_rdata : '0;
endmodule

// File: tb/tb_misao_mem_responder.sv
// Randomized self-checking bench for misao_mem_responder.
// The reference is a plain byte array updated from the loader/core rules.
module tb_misao_mem_responder;
  localparam int DEPTH     = 256;
  localparam int WPROT_TOP = 64;
`ifdef MISAO_MEM_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld_valid = 1'b0;
  logic       boot_skip = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic       ld_ready, core_rst, oob_err, wprot_err;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] model [DEPTH];
  logic [7:0] data_q [$];
  bit         exp_oob, exp_wprot;

  misao_mem_responder_if bus();

  misao_mem_responder #(.DEPTH(DEPTH), .WPROT_TOP(WPROT_TOP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .boot_skip (boot_skip),
    .core_rst  (core_rst),
    .oob_err   (oob_err),
    .wprot_err (wprot_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_bus();
    bus.mem_enable_read  = 1'b0;
    bus.mem_enable_write = 1'b0;
    bus.mem_rw           = 1'b0;
    bus.mem_addr         = '0;
    bus.mem_data_out     = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ld_valid = 1'b0;
    boot_skip = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    exp_oob = 1'b0;
    exp_wprot = 1'b0;
  endtask

  task automatic rd(input int a, output logic [7:0] d);
    bus.mem_addr = 15'(a);
    #1;
    d = bus.mem_data_in;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bs);
    int gaps;
    gaps = $urandom_range(0, 2);
    boot_skip = bs;
    ld_valid = 1'b0;
    repeat (gaps) tick();
    ld_valid = 1'b1;
    ld_data = b;
    tick();
    ld_valid = 1'b0;
    boot_skip = 1'b0;
  endtask

  // Sends header + data_q; model is updated from start address modulo DEPTH
  task automatic send_load(input int addr, input int len, input bit rnd_skip);
    logic [7:0] hdr [4];
    hdr[0] = addr[7:0];
    hdr[1] = addr[15:8];
    hdr[2] = len[7:0];
    hdr[3] = len[15:8];
    for (int i = 0; i < 4; i++)
      send_byte(hdr[i], rnd_skip && (i > 0) && ($urandom_range(0, 1) == 1));
    for (int i = 0; i < len; i++) begin
      send_byte(data_q[i], rnd_skip && ($urandom_range(0, 1) == 1));
      model[(addr + i) % DEPTH] = data_q[i];
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    idle_bus();
    do_reset();
    checks++;
    if (core_rst !== 1'b1 || ld_ready !== 1'b1 || oob_err !== 1'b0 || wprot_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got core_rst=%b ld_ready=%b oob=%b wprot=%b want 1 1 0 0",
               core_rst, ld_ready, oob_err, wprot_err);
    end
    rd(DEPTH + 3, d);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL oob_read_zero got %h want 00", d);
    end
  endtask

  task automatic test_full_load();
    logic [7:0] d;
    do_reset();
    data_q.delete();
    for (int i = 0; i < DEPTH; i++) data_q.push_back(8'($urandom));
    send_load(0, DEPTH, 1'b0);
    checks++;
    if (core_rst !== 1'b1 || ld_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_load_end got core_rst=%b ld_ready=%b want 1 0", core_rst, ld_ready);
    end
    tick();
    checks++;
    if (core_rst !== 1'b0) begin
      failures++;
      $display("FAIL full_load_release got core_rst=%b want 0", core_rst);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd(i, d);
      checks++;
      if (d !== model[i]) begin
        failures++;
        $display("FAIL full_load_mem[%0h] got %h want %h", i, d, model[i]);
      end
    end
  endtask

  task automatic test_core_ignored();
    logic [7:0] d;
    do_reset();
    bus.mem_enable_write = 1'b1;
    bus.mem_enable_read  = 1'b1;
    bus.mem_data_out     = ~model[5];
    bus.mem_addr         = 15'h0005;
    tick();
    bus.mem_addr = 15'h0010;
    bus.mem_data_out = ~model[16];
    tick();
    bus.mem_addr = 15'h1FF0;
    tick();
    idle_bus();
    checks++;
    if (oob_err !== 1'b0 || wprot_err !== 1'b0 || core_rst !== 1'b1 || ld_ready !== 1'b1) begin
      failures++;
      $display("FAIL core_ignored_flags got oob=%b wprot=%b core_rst=%b ld_ready=%b want 0 0 1 1",
               oob_err, wprot_err, core_rst, ld_ready);
    end
    rd(5, d);
    checks++;
    if (d !== model[5]) begin
      failures++;
      $display("FAIL core_ignored_mem5 got %h want %h", d, model[5]);
    end
    rd(16, d);
    checks++;
    if (d !== model[16]) begin
      failures++;
      $display("FAIL core_ignored_mem10 got %h want %h", d, model[16]);
    end
  endtask

  task automatic test_spec_stream();
    logic [7:0] d;
    do_reset();
    data_q = '{8'hAA, 8'hBB, 8'hCC};
    send_load(0, 3, 1'b0);
    checks++;
    if (core_rst !== 1'b1 || ld_ready !== 1'b0) begin
      failures++;
      $display("FAIL stream_last_edge got core_rst=%b ld_ready=%b want 1 0", core_rst, ld_ready);
    end
    tick();
    checks++;
    if (core_rst !== 1'b0) begin
      failures++;
      $display("FAIL stream_release got core_rst=%b want 0", core_rst);
    end
    for (int i = 0; i < 3; i++) begin
      rd(i, d);
      checks++;
      if (d !== data_q[i]) begin
        failures++;
        $display("FAIL stream_mem[%0d] got %h want %h", i, d, data_q[i]);
      end
    end
  endtask

  task automatic test_boot_skip();
    logic [7:0] d;
    do_reset();
    boot_skip = 1'b1;
    tick();
    boot_skip = 1'b0;
    checks++;
    if (core_rst !== 1'b1 || ld_ready !== 1'b0) begin
      failures++;
      $display("FAIL skip_edge1 got core_rst=%b ld_ready=%b want 1 0", core_rst, ld_ready);
    end
    tick();
    checks++;
    if (core_rst !== 1'b0) begin
      failures++;
      $display("FAIL skip_edge2 got core_rst=%b want 0", core_rst);
    end
    // Loader traffic in the terminal state must not touch memory
    ld_valid = 1'b1;
    repeat (5) begin
      ld_data = 8'($urandom);
      boot_skip = 1'($urandom);
      tick();
    end
    ld_valid = 1'b0;
    boot_skip = 1'b0;
    checks++;
    if (ld_ready !== 1'b0 || core_rst !== 1'b0) begin
      failures++;
      $display("FAIL skip_terminal got ld_ready=%b core_rst=%b want 0 0", ld_ready, core_rst);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd(i, d);
      checks++;
      if (d !== model[i]) begin
        failures++;
        $display("FAIL skip_mem[%0h] got %h want %h", i, d, model[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    int idx [3];
    idx = '{254, 255, 0};
    do_reset();
    data_q = '{8'h11, 8'h22, 8'h33};
    send_load(16'h00FE, 3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rd(idx[i], d);
      checks++;
      if (d !== data_q[i]) begin
        failures++;
        $display("FAIL wrap_mem[%0h] got %h want %h", idx[i], d, data_q[i]);
      end
    end
  endtask

  task automatic test_random_loads();
    logic [7:0] d;
    int addr, len;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      addr = $urandom_range(0, 65535);
      case ($urandom_range(0, 3))
        0:       len = 0;
        3:       len = $urandom_range(250, 300);
        default: len = $urandom_range(1, 40);
      endcase
      if (it == 0) len = 0;
      data_q.delete();
      for (int i = 0; i < len; i++) data_q.push_back(8'($urandom));
      send_load(addr, len, 1'b1);
      checks++;
      if (core_rst !== 1'b1 || ld_ready !== 1'b0) begin
        failures++;
        $display("FAIL rand_load_end it=%0d len=%0d got core_rst=%b ld_ready=%b want 1 0",
                 it, len, core_rst, ld_ready);
      end
      tick();
      checks++;
      if (core_rst !== 1'b0 || oob_err !== 1'b0 || wprot_err !== 1'b0) begin
        failures++;
        $display("FAIL rand_load_release it=%0d got core_rst=%b oob=%b wprot=%b want 0 0 0",
                 it, core_rst, oob_err, wprot_err);
      end
      for (int i = 0; i < DEPTH; i++) begin
        rd(i, d);
        checks++;
        if (d !== model[i]) begin
          failures++;
          $display("FAIL rand_load_mem it=%0d [%0h] got %h want %h", it, i, d, model[i]);
        end
      end
    end
  endtask

  task automatic test_core();
    logic [7:0] d, wd, exp_rd;
    int a;
    bit wr, rdn;
    do_reset();
    boot_skip = 1'b1;
    tick();
    boot_skip = 1'b0;
    tick();
    // Directed: protected region then out-of-range write
    bus.mem_enable_write = 1'b1;
    bus.mem_rw = 1'b1;
    bus.mem_addr = 15'h0010;
    bus.mem_data_out = 8'h77;
    tick();
    if (WPROT) exp_wprot = 1'b1;
    else model[16] = 8'h77;
    bus.mem_addr = 15'h0050;
    tick();
    model[80] = 8'h77;
    idle_bus();
    checks++;
    if (wprot_err !== exp_wprot || oob_err !== 1'b0) begin
      failures++;
      $display("FAIL wprot_flag got wprot=%b oob=%b want %b 0", wprot_err, oob_err, exp_wprot);
    end
    rd(16, d);
    checks++;
    if (d !== model[16]) begin
      failures++;
      $display("FAIL wprot_mem10 got %h want %h", d, model[16]);
    end
    rd(80, d);
    checks++;
    if (d !== 8'h77) begin
      failures++;
      $display("FAIL core_write_mem50 got %h want 77", d);
    end
    bus.mem_enable_write = 1'b1;
    bus.mem_addr = 15'h0100;
    bus.mem_data_out = 8'h5A;
    tick();
    exp_oob = 1'b1;
    bus.mem_enable_write = 1'b0;
    checks++;
    if (oob_err !== 1'b1) begin
      failures++;
      $display("FAIL oob_flag got %b want 1", oob_err);
    end
    rd(16'h0100, d);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL oob_read got %h want 00", d);
    end
    rd(0, d);
    checks++;
    if (d !== model[0]) begin
      failures++;
      $display("FAIL oob_no_alias got %h want %h", d, model[0]);
    end
    // Random core traffic against the array model
    repeat (300) begin
      a   = ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH, 32767) : $urandom_range(0, DEPTH - 1);
      wr  = 1'($urandom);
      rdn = 1'($urandom);
      wd  = 8'($urandom);
      bus.mem_addr = 15'(a);
      bus.mem_enable_write = wr;
      bus.mem_enable_read = rdn;
      bus.mem_rw = wr;
      bus.mem_data_out = wd;
      #1;
      exp_rd = (a < DEPTH) ? model[a] : 8'h00;
      checks++;
      if (bus.mem_data_in !== exp_rd) begin
        failures++;
        $display("FAIL core_read[%0h] got %h want %h", a, bus.mem_data_in, exp_rd);
      end
      tick();
      if ((wr || rdn) && a >= DEPTH) exp_oob = 1'b1;
      else if (wr && a < DEPTH) begin
        if (WPROT && a < WPROT_TOP) exp_wprot = 1'b1;
        else model[a] = wd;
      end
      checks++;
      if (oob_err !== exp_oob || wprot_err !== exp_wprot) begin
        failures++;
        $display("FAIL core_flags got oob=%b wprot=%b want %b %b", oob_err, wprot_err, exp_oob, exp_wprot);
      end
    end
    idle_bus();
    // Asynchronous reset from the running state, checked before any edge
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (core_rst !== 1'b1 || ld_ready !== 1'b1 || oob_err !== 1'b0 || wprot_err !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got core_rst=%b ld_ready=%b oob=%b wprot=%b want 1 1 0 0",
               core_rst, ld_ready, oob_err, wprot_err);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_midload();
    logic [7:0] d;
    do_reset();
    send_byte(8'h40, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hE1, 1'b0); model[64] = 8'hE1;
    send_byte(8'hE2, 1'b0); model[65] = 8'hE2;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (core_rst !== 1'b1 || ld_ready !== 1'b1) begin
      failures++;
      $display("FAIL midload_reset got core_rst=%b ld_ready=%b want 1 1", core_rst, ld_ready);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    data_q = '{8'h9C};
    send_load(16'h0080, 1, 1'b0);
    checks++;
    if (ld_ready !== 1'b0) begin
      failures++;
      $display("FAIL midload_new_header got ld_ready=%b want 0", ld_ready);
    end
    tick();
    checks++;
    if (core_rst !== 1'b0) begin
      failures++;
      $display("FAIL midload_release got core_rst=%b want 0", core_rst);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd(i, d);
      checks++;
      if (d !== model[i]) begin
        failures++;
        $display("FAIL midload_mem[%0h] got %h want %h", i, d, model[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_core_ignored();
    test_spec_stream();
    test_boot_skip();
    test_wrap();
    test_random_loads();
    test_core();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
